// File: rtl/klotski_sort_ctrl.sv
// rtl/klotski_sort_ctrl.sv - sequences the block sorter, validates its labels and publishes stable boards
module klotski_sort_ctrl #(
   parameter int STABLE_COUNT = 3,
   parameter int TIMEOUT      = 64
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_enable,
   input  logic         i_frame_done,
   input  logic [383:0] i_colors,
   output logic         o_sort_start,
   output logic [383:0] o_sort_blocks,
   input  logic         i_sort_done,
   input  logic [63:0]  i_sort_order,
   output logic [63:0]  o_order,
   output logic         o_order_valid,
   output logic         o_busy,
   output logic         o_err_timeout,
   output logic         o_err_invalid,
   output logic [7:0]   o_drop_cnt
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_DECIDE = 3'd4;

   localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   logic [2:0]   state_q, state_d;
   logic [7:0]   timer_q, timer_d;
   logic [3:0]   idx_q, idx_d;
   logic [15:0]  seen_q, seen_d;
   logic         dup_q, dup_d;
   logic [63:0]  cand_q, cand_d;
   logic [63:0]  last_q, last_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [383:0] blocks_q, blocks_d;
   logic [63:0]  order_q, order_d;
   logic         start_q, start_d;
   logic         valid_q, valid_d;
   logic         tmo_q, tmo_d;
   logic         inv_q, inv_d;
   logic         busy_q, busy_d;
   logic [7:0]   drop_q, drop_d;
   logic [3:0]   nib;

   // idx 0 addresses the most significant nibble
   assign nib = cand_q[{~idx_q, 2'b00} +: 4];

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      idx_d    = idx_q;
      seen_d   = seen_q;
      dup_d    = dup_q;
      cand_d   = cand_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      blocks_d = blocks_q;
      order_d  = order_q;
      drop_d   = drop_q;
      start_d  = 1'b0;
      valid_d  = 1'b0;
      tmo_d    = 1'b0;
      inv_d    = 1'b0;

      if (i_frame_done && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (!i_enable) begin
               cnt_d = 4'd0;
            end else if (i_frame_done) begin
               blocks_d = i_colors;
               start_d  = 1'b1;
               state_d  = S_START;
            end
         end
         S_START: begin
            timer_d = 8'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_sort_done) begin
               cand_d  = i_sort_order;
               seen_d  = 16'd0;
               dup_d   = 1'b0;
               idx_d   = 4'd0;
               state_d = S_CHECK;
            end else if (timer_q == TIMER_LAST) begin
               tmo_d   = 1'b1;
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_CHECK: begin
            if (seen_q[nib]) dup_d = 1'b1;
            seen_d = seen_q | (16'd1 << nib);
            idx_d  = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = S_DECIDE;
         end
         S_DECIDE: begin
            state_d = S_IDLE;
            if (dup_q) begin
               inv_d = 1'b1;
               cnt_d = 4'd0;
            end else begin
               if (cand_q == last_q) begin
                  if (cnt_q != STABLE_MAX) cnt_d = cnt_q + 4'd1;
               end else begin
                  last_d = cand_q;
                  cnt_d  = 4'd1;
               end
               // a new board reaching the threshold counts as a transition even from a saturated count
               if ((cnt_d == STABLE_MAX) && ((cand_q != last_q) || (cnt_q != STABLE_MAX))) begin
                  order_d = cand_q;
                  valid_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         idx_q    <= '0;
         seen_q   <= '0;
         dup_q    <= 1'b0;
         cand_q   <= '0;
         last_q   <= '0;
         cnt_q    <= '0;
         blocks_q <= '0;
         order_q  <= '0;
         start_q  <= 1'b0;
         valid_q  <= 1'b0;
         tmo_q    <= 1'b0;
         inv_q    <= 1'b0;
         busy_q   <= 1'b0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         seen_q   <= seen_d;
         dup_q    <= dup_d;
         cand_q   <= cand_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         blocks_q <= blocks_d;
         order_q  <= order_d;
         start_q  <= start_d;
         valid_q  <= valid_d;
         tmo_q    <= tmo_d;
         inv_q    <= inv_d;
         busy_q   <= busy_d;
         drop_q   <= drop_d;
      end
   end

   assign o_sort_start  = start_q;
   assign o_sort_blocks = blocks_q;
   assign o_order       = order_q;
   assign o_order_valid = valid_q;
   assign o_busy        = busy_q;
   assign o_err_timeout = tmo_q;
   assign o_err_invalid = inv_q;
   assign o_drop_cnt    = drop_q;
endmodule

// File: doc/klotski_sort_ctrl.md
# klotski_sort_ctrl

Sequencer that owns the RGB block sorter in the Klotski camera path. On each frame-done pulse from the block-colour accumulator it snapshots the 16 block colours and issues a start pulse to the sorter. It then waits for the sorter's done with a timeout, checks that the returned 16-label board is a permutation of 0..15, and publishes a board only after it has been identical for STABLE_COUNT consecutive frames. Downstream (solver/display) sees only stable, valid boards.

## Interface
- STABLE_COUNT, 3: consecutive identical valid boards required to publish (1..15).
- TIMEOUT, 64: max WAIT cycles for sorter done (2..255).

- i_clk  in  1  system clock.
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- i_enable  in  1  gates acceptance of new frames.
- i_frame_done  in  1  one-cycle pulse: i_colors valid this cycle.
- i_colors  in  384  block k colour at [24k+23:24k], {R,G,B} 8 bits each.
- o_sort_start  out  1  one-cycle start pulse to sorter.
- o_sort_blocks  out  384  latched colours driven to sorter blocks 0..15 (same packing).
- i_sort_done  in  1  sorter done pulse.
- i_sort_order  in  64  sorter result; position 0 label in [63:60], position 15 in [3:0].
- o_order  out  64  last published board, same packing.
- o_order_valid  out  1  one-cycle pulse: o_order updated.
- o_busy  out  1  high in every state except IDLE.
- o_err_timeout  out  1  one-cycle pulse: sorter did not finish.
- o_err_invalid  out  1  one-cycle pulse: result not a permutation.
- o_drop_cnt  out  8  saturating count of frames ignored while busy.

## Operation
- States: IDLE, START, WAIT, CHECK, DECIDE.
- IDLE: if i_enable & i_frame_done, latch i_colors into o_sort_blocks, go to START. If i_enable=0, clear stable count (o_order retained).
- START: o_sort_start=1 for exactly this cycle; clear timer; go to WAIT.
- WAIT: if i_sort_done, capture i_sort_order into cand, clear the 16-bit seen mask and dup flag, set idx=0, go to CHECK. Otherwise increment timer. On the TIMEOUT-th WAIT cycle without done, go to IDLE, pulse o_err_timeout and clear stable count. Done in the same cycle as expiry: done wins.
- CHECK: one nibble per cycle, idx 0..15 (idx 0 = [63:60]). Set dup if seen[nib] is already 1; set seen[nib]. At idx=15 go to DECIDE.
- DECIDE: if dup, pulse o_err_invalid, clear stable count, go to IDLE. Otherwise:
  - if cand==last, stable count increments, saturating at STABLE_COUNT;
  - else last=cand and count=1.
  - If count transitions to STABLE_COUNT in this cycle (including STABLE_COUNT=1), o_order<=cand and o_order_valid pulses.
  - Go to IDLE.
- A held identical board publishes once only; no repeat pulses while count is saturated.
- i_frame_done outside IDLE: ignored; o_drop_cnt++ (saturates at 255). i_enable deassert mid-operation: current frame completes normally.
- i_sort_done outside WAIT: ignored.

## Timing
- Reset values: all outputs 0; cand, last, stable count, timer, idx, seen all 0; state IDLE.
- frame_done accepted at cycle 0 → o_sort_start high at cycle 1 → WAIT from cycle 2.
- Done seen at WAIT cycle D → CHECK D+1..D+16 → DECIDE D+17. o_order, o_order_valid, or error pulse registered at D+18, with state IDLE at D+18. A frame_done at D+18 is accepted.
- Timeout pulse registered the cycle after the expiring WAIT cycle.
- All outputs are registered; no combinational input→output paths.
- Reset asserted mid-operation returns to IDLE immediately; no pulses are emitted.

## Test plan
- Reset: assert i_rst mid-WAIT → all outputs 0, o_busy=0 next edge. After release, a frame_done produces o_sort_start exactly 1 cycle later.
- Stability, STABLE_COUNT=3: three frames, sorter returns 64'h0123456789ABCDEF each time → o_order_valid only after the third, o_order=64'h0123456789ABCDEF. A fourth identical frame gives no pulse.
- Change resets count: boards A, A, B, B, B → a single publish, of B, on the fifth frame.
- Invalid: return 64'h1123456789ABCDEF → o_err_invalid pulse at D+18, no publish, count cleared (next valid A needs 3 more frames).
- Timeout, TIMEOUT=64: never assert done → o_err_timeout one cycle after the 64th WAIT cycle, then IDLE. Done on the 64th WAIT cycle → no error, CHECK proceeds.
- Drops: frame_done pulses on 300 cycles while busy → o_drop_cnt=255 and the in-flight frame is unaffected; i_enable=0 in IDLE with frame_done → no start.
